// File: rtl/hazard_ctrl_if.sv
// Hazard-unit signal bundle: pipeline status in, stall/flush/redirect controls and perf counters out.
// master = pipeline side driving status, slave = hazard_ctrl.
interface hazard_ctrl_if;
   logic [31:0] id_inst;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic        ex_branch_taken;
   logic [31:0] ex_target;
   logic        trap_req;
   logic [31:0] trap_vec;
   logic        stall;
   logic        flush;
   logic        pc_src;
   logic [31:0] pc_jump;
   logic        fl_signal;
   logic [31:0] fl_pc;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   modport master (
      output id_inst, ex_mem_read, ex_rd, ex_branch_taken, ex_target, trap_req, trap_vec,
      input  stall, flush, pc_src, pc_jump, fl_signal, fl_pc, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_inst, ex_mem_read, ex_rd, ex_branch_taken, ex_target, trap_req, trap_vec,
      output stall, flush, pc_src, pc_jump, fl_signal, fl_pc, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: 1-cycle load-use stall, 2-cycle flush on branch redirect or trap; outputs are
// combinational from state and inputs, no backpressure. Define HAZARD_PERF_EN for saturating stall/flush counters.
module hazard_ctrl (
   input logic        clk,
   input logic        rst,
   hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      REDIRECT = 2'd2,
      TRAP     = 2'd3
   } state_t;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  opcode;
   logic        rs2_used;
   logic        load_use;
   logic        stall_c;
   logic        flush_c;
   logic        pc_src_c;
   logic [31:0] pc_jump_c;
   logic        fl_signal_c;
   logic [31:0] fl_pc_c;
   logic        unused_bits;

   assign opcode   = hz.id_inst[6:0];
   assign rs1      = hz.id_inst[19:15];
   assign rs2      = hz.id_inst[24:20];
   assign rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

   // x0 is never a real dependency, so a load into x0 can never stall.
   assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                     ((hz.ex_rd == rs1) || (rs2_used && (hz.ex_rd == rs2)));

   assign unused_bits = ^{hz.id_inst[31:25], hz.id_inst[14:7], hz.ex_target[1:0], hz.trap_vec[1:0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      stall_c     = 1'b0;
      flush_c     = 1'b0;
      pc_src_c    = 1'b0;
      pc_jump_c   = 32'd0;
      fl_signal_c = 1'b0;
      fl_pc_c     = 32'd0;
      if (!rst) begin
         state_nxt = RUN;
         flush_c   = 1'b1;
      end else if (hz.trap_req) begin
         // Trap wins over everything, including a trap already in progress.
         state_nxt   = TRAP;
         fl_signal_c = 1'b1;
         fl_pc_c     = {hz.trap_vec[31:2], 2'b00};
         flush_c     = 1'b1;
      end else begin
         case (state)
            RUN, LU_STALL: begin
               if (hz.ex_branch_taken) begin
                  state_nxt = REDIRECT;
                  pc_src_c  = 1'b1;
                  pc_jump_c = {hz.ex_target[31:2], 2'b00};
                  flush_c   = 1'b1;
               end else if ((state == RUN) && load_use) begin
                  state_nxt = LU_STALL;
                  stall_c   = 1'b1;
               end else begin
                  state_nxt = RUN;
               end
            end
            REDIRECT, TRAP: begin
               // Second flush cycle; squashes the instruction fetched during the redirect.
               state_nxt = RUN;
               flush_c   = 1'b1;
            end
            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

   assign hz.stall     = stall_c;
   assign hz.flush     = flush_c;
   assign hz.pc_src    = pc_src_c;
   assign hz.pc_jump   = pc_jump_c;
   assign hz.fl_signal = fl_signal_c;
   assign hz.fl_pc     = fl_pc_c;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (flush_c && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`else
   assign hz.stall_cnt = 32'd0;
   assign hz.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed test of hazard_ctrl: load-use, branch redirect, trap priority, reset cancel, perf counters.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if hz ();

   hazard_ctrl dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hz.id_inst         = 32'd0;
      hz.ex_mem_read     = 1'b0;
      hz.ex_rd           = 5'd0;
      hz.ex_branch_taken = 1'b0;
      hz.ex_target       = 32'd0;
      hz.trap_req        = 1'b0;
      hz.trap_vec        = 32'd0;
   endtask

   task automatic load_use();
      hz.ex_mem_read = 1'b1;
      hz.ex_rd       = 5'd5;
      hz.id_inst     = 32'h0052_8633;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      rst = 1'b0;
      tick();
      tick();
      #2;
      check("rst_stall", hz.stall, 0);
      check("rst_flush", hz.flush, 1);
      check("rst_pc_src", hz.pc_src, 0);
      check("rst_fl_signal", hz.fl_signal, 0);
      check("rst_pc_jump", hz.pc_jump, 0);
      check("rst_fl_pc", hz.fl_pc, 0);
      check("rst_stall_cnt", hz.stall_cnt, 0);
      check("rst_flush_cnt", hz.flush_cnt, 0);

      tick(); rst = 1'b1; idle(); #2;
      check("idle_stall", hz.stall, 0);
      check("idle_flush", hz.flush, 0);

      // add x12,x5,x5 behind a load to x5
      tick(); load_use(); #2;
      check("lu_stall", hz.stall, 1);
      check("lu_flush", hz.flush, 0);
      tick(); #2;
      check("lu_one_cycle", hz.stall, 0);
      tick(); idle(); #2;
      check("lu_done", hz.stall, 0);

      // sw x5,0(x6): rs2 used by store
      tick(); hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_inst = 32'h0053_2023; #2;
      check("lu_store_rs2", hz.stall, 1);
      tick(); idle(); #2;
      check("lu_store_end", hz.stall, 0);

      // addi x1,x6,5: rs2 field matches but is an immediate
      tick(); hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_inst = 32'h0053_0093; #2;
      check("itype_no_rs2", hz.stall, 0);

      tick(); hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_inst = 32'h0000_0033; #2;
      check("rd_zero", hz.stall, 0);

      tick(); idle(); hz.ex_branch_taken = 1'b1; hz.ex_target = 32'h0000_0103; #2;
      check("br_pc_src", hz.pc_src, 1);
      check("br_pc_jump", hz.pc_jump, 32'h0000_0100);
      check("br_flush", hz.flush, 1);
      check("br_stall", hz.stall, 0);
      tick(); load_use(); #2;
      check("redir_pc_src", hz.pc_src, 0);
      check("redir_pc_jump", hz.pc_jump, 0);
      check("redir_flush", hz.flush, 1);
      check("redir_stall", hz.stall, 0);
      tick(); idle(); #2;
      check("redir_end_flush", hz.flush, 0);

      // trap beats branch and load-use in the same cycle
      tick(); load_use(); hz.ex_branch_taken = 1'b1; hz.ex_target = 32'h200;
      hz.trap_req = 1'b1; hz.trap_vec = 32'h80; #2;
      check("trap_fl_signal", hz.fl_signal, 1);
      check("trap_fl_pc", hz.fl_pc, 32'h80);
      check("trap_pc_src", hz.pc_src, 0);
      check("trap_pc_jump", hz.pc_jump, 0);
      check("trap_stall", hz.stall, 0);
      check("trap_flush", hz.flush, 1);
      tick(); hz.trap_req = 1'b0; #2;
      check("trap2_fl_signal", hz.fl_signal, 0);
      check("trap2_fl_pc", hz.fl_pc, 0);
      check("trap2_pc_src", hz.pc_src, 0);
      check("trap2_stall", hz.stall, 0);
      check("trap2_flush", hz.flush, 1);
      tick(); idle(); #2;
      check("trap_end_flush", hz.flush, 0);

      tick(); hz.trap_req = 1'b1; hz.trap_vec = 32'h8000_0007; #2;
      check("trap_align", hz.fl_pc, 32'h8000_0004);
      tick(); hz.trap_vec = 32'h123; #2;
      check("trap_reenter_sig", hz.fl_signal, 1);
      check("trap_reenter_pc", hz.fl_pc, 32'h120);
      tick(); idle(); #2;
      check("trap_reenter_flush", hz.flush, 1);
      check("trap_reenter_sig0", hz.fl_signal, 0);
      tick(); #2;
      check("trap_reenter_end", hz.flush, 0);

      // branch arriving while in LU_STALL
      tick(); load_use(); #2;
      check("lu_pre_br", hz.stall, 1);
      tick(); idle(); hz.ex_branch_taken = 1'b1; hz.ex_target = 32'h44; #2;
      check("lu_br_pc_src", hz.pc_src, 1);
      check("lu_br_pc_jump", hz.pc_jump, 32'h44);
      tick(); idle(); #2;
      check("lu_br_flush2", hz.flush, 1);
      tick(); #2;
      check("lu_br_end", hz.flush, 0);

      // reset in the middle of REDIRECT
      tick(); hz.ex_branch_taken = 1'b1; hz.ex_target = 32'h10; #2;
      check("pre_rst_pc_src", hz.pc_src, 1);
      tick(); idle(); rst = 1'b0; #2;
      check("in_rst_pc_src", hz.pc_src, 0);
      check("in_rst_flush", hz.flush, 1);
      tick(); rst = 1'b1; load_use(); #2;
      check("post_rst_stall", hz.stall, 1);
      check("post_rst_pc_src", hz.pc_src, 0);
      check("post_rst_stall_cnt", hz.stall_cnt, 0);
      check("post_rst_flush_cnt", hz.flush_cnt, 0);

      // reset in the middle of LU_STALL, load-use still present afterwards
      tick(); rst = 1'b0; #2;
      check("lu_rst_stall", hz.stall, 0);
      tick(); rst = 1'b1; #2;
      check("rst_cancels_lu", hz.stall, 1);

      tick(); idle();
      tick(); load_use();
      tick(); idle();
      tick(); hz.ex_branch_taken = 1'b1;
      tick(); idle();
      tick(); #2;
      check("cnt_stall", hz.stall_cnt, PERF ? 32'd2 : 32'd0);
      check("cnt_flush", hz.flush_cnt, PERF ? 32'd2 : 32'd0);

`ifdef HAZARD_PERF_EN
      dut.stall_cnt_q = 32'hFFFF_FFFE;
`endif
      for (int i = 0; i < 3; i++) begin
         tick(); load_use();
         tick(); idle();
      end
      tick(); #2;
      check("cnt_stall_sat", hz.stall_cnt, PERF ? 32'hFFFF_FFFF : 32'd0);
      check("cnt_flush_hold", hz.flush_cnt, PERF ? 32'd2 : 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: id_inst  in  32  instruction held in the IF/ID register.
REQ-004 SHALL have: ex_mem_read  in  1  EX-stage instruction is a load.
REQ-005 SHALL have: ex_rd  in  5  EX-stage destination register.
REQ-006 SHALL have: ex_branch_taken  in  1  EX-stage branch or jump resolved taken.
REQ-007 SHALL have: ex_target  in  32  EX-stage resolved target address.
REQ-008 SHALL have: trap_req  in  1  one-cycle trap/exception request.
REQ-009 SHALL have: trap_vec  in  32  trap handler address.
REQ-010 SHALL have: stall  out  1  1 = hold PC and IF/ID register.
REQ-011 SHALL have: flush  out  1  1 = IF/ID and ID/EX contents discarded.
REQ-012 SHALL have: pc_src  out  1  1 = fetch takes pc_jump.
REQ-013 SHALL have: pc_jump  out  32  branch redirect address.
REQ-014 SHALL have: fl_signal  out  1  1 = fetch takes fl_pc.
REQ-015 SHALL have: fl_pc  out  32  trap redirect address.
REQ-016 SHALL have: stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-017 SHALL run an FSM with states RUN, LU_STALL, REDIRECT, TRAP; encoding is free.
REQ-018 SHALL decode rs1=id_inst[19:15], rs2=id_inst[24:20]; rs2 counts as used only when opcode id_inst[6:0] is 0110011, 0100011 or 1100011.
REQ-019 SHALL detect load-use: ex_mem_read=1, ex_rd!=0, and ex_rd matches rs1 or a used rs2.
REQ-020 SHALL, in RUN with load-use, assert stall=1 combinationally that cycle and enter LU_STALL; LU_STALL drives stall=0 and returns to RUN after exactly 1 cycle, so the stall is never longer than 1 cycle per load.
REQ-021 SHALL, in RUN or LU_STALL with ex_branch_taken=1, drive pc_src=1, pc_jump={ex_target[31:2],2'b00}, flush=1, stall=0 that cycle and enter REDIRECT.
REQ-022 SHALL, in REDIRECT, hold flush=1 for one more cycle with pc_src=0, ignore ex_branch_taken and load-use, then return to RUN; flush therefore spans exactly 2 cycles.
REQ-023 SHALL, on trap_req=1 in any state, drive fl_signal=1, fl_pc={trap_vec[31:2],2'b00}, pc_src=0, stall=0, flush=1 that cycle and enter TRAP.
REQ-024 SHALL, in TRAP, hold flush=1 for 1 cycle, ignore all requests except a new trap_req (which re-enters TRAP), then return to RUN.
REQ-025 SHALL apply priority trap_req > ex_branch_taken > load-use when events coincide.
REQ-026 SHALL drive pc_jump and fl_pc to 0 whenever pc_src and fl_signal are 0, respectively.
REQ-027 SHALL never assert pc_src and fl_signal in the same cycle.

Reset
REQ-028 SHALL, when rst=0 at a clock edge, enter RUN and clear both counters.
REQ-029 SHALL drive stall=0, flush=1, pc_src=0, fl_signal=0, pc_jump=0 and fl_pc=0 while rst=0, so fetch state is discarded.
REQ-030 SHALL cancel any pending LU_STALL, REDIRECT or TRAP cycle when reset occurs mid-sequence.

Configuration
REQ-031 SHALL, with macro HAZARD_PERF_EN defined, increment stall_cnt on each cycle with stall=1 and flush_cnt on each cycle with flush=1 (outside reset), both saturating at 32'hFFFFFFFF.
REQ-032 SHALL, without HAZARD_PERF_EN, tie stall_cnt and flush_cnt to 0 and instantiate no counter flops; ports remain present.

Verification
REQ-033 SHALL cover this case: ex_mem_read=1, ex_rd=5, id_inst=32'h00528633 (add x12,x5,x5) -> stall=1 for exactly 1 cycle, then 0.
REQ-034 SHALL cover this case: ex_mem_read=1, ex_rd=0 with rs1=0 -> stall stays 0.
REQ-035 SHALL cover this case: ex_branch_taken=1, ex_target=32'h00000103 -> pc_src=1 and pc_jump=32'h00000100 for 1 cycle, flush=1 for 2 cycles.
REQ-036 SHALL cover this case: trap_req=1 with ex_branch_taken=1 and load-use in the same cycle, trap_vec=32'h80 -> fl_signal=1, fl_pc=32'h80, pc_src=0, stall=0, flush=1 for 2 cycles.
REQ-037 SHALL cover this case: rst=0 asserted during REDIRECT -> next cycle state RUN and pc_src=0; with HAZARD_PERF_EN, both counters read 0.
REQ-038 SHALL cover this case: HAZARD_PERF_EN with stall_cnt preloaded to 32'hFFFFFFFE, then 3 load-use stalls -> stall_cnt=32'hFFFFFFFF.
